// File: rtl/seq_mul_pkg.sv
// Shared widths, sequencing constants and FSM state encoding for the
// shared price x quantity multiplier and its arbiter.
package seq_mul_pkg;

    localparam int PRICE_W    = 12;
    localparam int NUM_W      = 3;
    localparam int RES_W      = 16;
    localparam int MUL_CYCLES = 3;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // One shift-add step: price shifted by the bit position when that quantity bit is set.
    function automatic logic [RES_W-1:0] partial_product(
        input logic [PRICE_W-1:0] price,
        input logic               bit_set,
        input logic [CNT_W-1:0]   shift
    );
        return bit_set ? (RES_W'(price) << shift) : '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching ptr+1, ptr+2, ... mod NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        int k;
        k     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(i_ptr) + i) % NREQ;
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/seq_mul.sv
// Shift-add multiplier, 12b price x 3b quantity -> 16b, one quantity bit per step.
// i_enable clears the accumulator, i_sm_en performs one step; neither holds state.
module seq_mul
    import seq_mul_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_sm_en,
    input  logic [PRICE_W-1:0] i_price,
    input  logic [NUM_W-1:0]   i_num,
    output logic [RES_W-1:0]   o_product
);

    logic [RES_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             num_bit;

    always_comb begin
        acc_d   = acc_q;
        bit_d   = bit_q;
        num_bit = i_num[bit_q];
        if (i_enable) begin
            acc_d = '0;
            bit_d = '0;
        end else if (i_sm_en) begin
            acc_d = acc_q + partial_product(i_price, num_bit, bit_q);
            bit_d = (bit_q == CNT_W'(MUL_CYCLES - 1)) ? '0 : bit_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
            bit_q <= '0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    // Look-ahead value: lets the caller capture the finished sum on the last step edge.
    assign o_product = acc_d;

endmodule

// File: rtl/seq_mul_arbiter.sv
// Shares one seq_mul between NREQ requesters: round-robin grant in IDLE, operand latch,
// clear + 3 accumulate cycles, then result returned with requester ID on a valid/ready port.
module seq_mul_arbiter
    import seq_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*PRICE_W-1:0] i_price,
    input  logic [NREQ*NUM_W-1:0]   i_num,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [RES_W-1:0]        o_result,
    output logic [IDW-1:0]          o_id,
    output logic                    o_busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [RES_W-1:0]   result_q, result_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;
    logic               mul_enable;
    logic               mul_sm_en;
    logic [RES_W-1:0]   mul_product;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .i_req (i_req),
        .i_ptr (ptr_q),
        .o_gnt (arb_gnt),
        .o_idx (arb_idx),
        .o_any (arb_any)
    );

    assign mul_enable = (state_q == ST_CLR);
    assign mul_sm_en  = (state_q == ST_MUL);

    seq_mul u_seq_mul (
        .i_clk     (i_clk),
        .i_rst     (~i_rst_n),
        .i_enable  (mul_enable),
        .i_sm_en   (mul_sm_en),
        .i_price   (price_q),
        .i_num     (num_q),
        .o_product (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        price_d  = price_q;
        num_d    = num_q;
        grant_d  = '0;
        valid_d  = valid_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    price_d = i_price[PRICE_W*arb_idx +: PRICE_W];
                    num_d   = i_num[NUM_W*arb_idx +: NUM_W];
                    id_d    = arb_idx;
                    ptr_d   = arb_idx;
                    grant_d = arb_gnt;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_d   = '0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Last step: the multiplier's look-ahead already holds the full product.
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    cnt_d    = '0;
                    result_d = mul_product;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ptr_q    <= IDW'(NREQ - 1);
            id_q     <= '0;
            price_q  <= '0;
            num_q    <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            price_q  <= price_d;
            num_q    <= num_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign o_grant  = grant_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_id     = id_q;
    assign o_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_mul_arbiter.sv
// Directed bench for seq_mul_arbiter: reset, single jobs, operand extremes,
// round-robin order, backpressure and mid-operation reset.
module tb_seq_mul_arbiter;

    logic        clk;
    logic        i_rst_n;
    logic [3:0]  i_req;
    logic [47:0] i_price;
    logic [11:0] i_num;
    logic [3:0]  o_grant;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_result;
    logic [1:0]  o_id;
    logic        o_busy;

    int n_pass  = 0;
    int n_total = 0;

    seq_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_price  (i_price),
        .i_num    (i_num),
        .o_grant  (o_grant),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_id     (o_id),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_grant != 4'b0000) break;
        end
    endtask

    // Called on the negedge where the grant is visible; ready must be high.
    task automatic finish_job(input string tag, input logic [15:0] exp_res, input logic [1:0] exp_id);
        int n;
        n = 0;
        while (!o_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_result"}, o_result, exp_res);
        chk({tag, "_id"}, o_id, exp_id);
        @(negedge clk);
        chk({tag, "_accepted"}, o_valid, 1'b0);
    endtask

    task automatic do_job(input string tag, input int k, input logic [11:0] p, input logic [2:0] n,
                          input logic [15:0] exp_res);
        logic [3:0] g;
        g    = 4'b0000;
        g[k] = 1'b1;
        i_price[12*k +: 12] = p;
        i_num[3*k +: 3]     = n;
        i_req[k]            = 1'b1;
        wait_grant();
        chk({tag, "_grant"}, o_grant, g);
        i_req[k] = 1'b0;
        finish_job(tag, exp_res, 2'(k));
    endtask

    initial begin
        int exp_rr[4];
        int n;
        exp_rr = '{30, 1400, 4095, 7404};

        // 1: reset with all requests high
        i_rst_n = 1'b1;
        i_req   = 4'hF;
        i_ready = 1'b1;
        i_price = '0;
        i_num   = '0;
        i_price[11:0] = 12'd7;
        i_num[2:0]    = 3'd3;
        #1 i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", o_grant, 4'b0000);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_result", o_result, 16'd0);
        chk("rst_id", o_id, 2'd0);
        chk("rst_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;
        wait_grant();
        chk("first_grant", o_grant, 4'b0001);
        i_req = 4'h0;
        finish_job("first_job", 16'd21, 2'd0);

        // 2 and 3: single jobs and operand extremes
        do_job("single", 2, 12'd100, 3'd5, 16'd500);
        do_job("max", 3, 12'd4095, 3'd7, 16'd28665);
        do_job("num0", 0, 12'd4095, 3'd0, 16'd0);
        do_job("price0", 1, 12'd0, 3'd7, 16'd0);
        do_job("num101", 2, 12'd3, 3'b101, 16'd15);

        // 4: round-robin from a fresh reset with all requests held
        @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        i_price = {12'd1234, 12'd4095, 12'd200, 12'd10};
        i_num   = {3'd6, 3'd1, 3'd7, 3'd3};
        i_req   = 4'hF;
        for (int j = 0; j < 5; j++) begin
            logic [3:0] g;
            g = 4'b0000;
            g[j % 4] = 1'b1;
            wait_grant();
            chk("rr_grant", o_grant, g);
            if (j == 4) i_req = 4'h0;
            finish_job("rr", 16'(exp_rr[j % 4]), 2'(j % 4));
        end

        // 5: backpressure in DONE with another request pending
        i_ready = 1'b0;
        i_price[23:12] = 12'd321;
        i_num[5:3]     = 3'd4;
        i_req[1]       = 1'b1;
        wait_grant();
        chk("bp_grant", o_grant, 4'b0010);
        i_req[1]     = 1'b0;
        i_price[11:0] = 12'd50;
        i_num[2:0]    = 3'd2;
        i_req[0]      = 1'b1;
        n = 0;
        while (!o_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", o_valid, 1'b1);
            chk("bp_result", o_result, 16'd1284);
            chk("bp_id", o_id, 2'd1);
            chk("bp_no_grant", o_grant, 4'b0000);
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_accepted", o_valid, 1'b0);
        chk("bp_idle", o_busy, 1'b0);
        wait_grant();
        chk("bp_next_grant", o_grant, 4'b0001);
        i_req[0] = 1'b0;
        finish_job("bp_next", 16'd100, 2'd0);

        // 6: reset during MUL cnt=1, then the same requester again
        i_price[35:24] = 12'd777;
        i_num[8:6]     = 3'd7;
        i_req[2]       = 1'b1;
        wait_grant();
        chk("midrst_grant", o_grant, 4'b0100);
        i_req[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_before", o_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_grant0", o_grant, 4'b0000);
        chk("midrst_result", o_result, 16'd0);
        chk("midrst_id", o_id, 2'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        do_job("after_rst", 2, 12'd777, 3'd7, 16'd5439);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
